// File: rtl/mod100_timer_ctrl.sv
// Start/stop/pause timer around a mod-100 count: prescaled ticks step the count
// up or down from a loaded value until a registered target is reached.
module mod100_timer_ctrl #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       dir,
  input  logic       load_en,
  input  logic [6:0] load_val,
  input  logic [6:0] target_val,
  output logic [6:0] count,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       wrap,
  output logic       err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [6:0]  MAX_COUNT  = 7'd99;

  state_t      state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic [6:0]  target_q, target_d;
  logic [15:0] presc_q, presc_d;
  logic        done_q, done_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;
  logic [6:0]  step_val;
  logic        step_wrap;

  // Value the count would take on a tick, with the mod-100 wrap in either direction.
  always_comb begin
    step_val  = count_q;
    step_wrap = 1'b0;
    if (dir) begin
      if (count_q == MAX_COUNT) begin
        step_val  = 7'd0;
        step_wrap = 1'b1;
      end else begin
        step_val = count_q + 7'd1;
      end
    end else begin
      if (count_q == 7'd0) begin
        step_val  = MAX_COUNT;
        step_wrap = 1'b1;
      end else begin
        step_val = count_q - 7'd1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    err_d    = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      count_d = 7'd0;
      presc_d = 16'd0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          // A stop here has nothing to pause but still masks the lower-priority commands.
          if (!stop) begin
            if (start) begin
              if (target_val <= MAX_COUNT) begin
                target_d = target_val;
                presc_d  = 16'd0;
                state_d  = ST_RUN;
              end else begin
                err_d = 1'b1;
              end
            end else if (load_en) begin
              if (load_val <= MAX_COUNT) begin
                count_d = load_val;
                state_d = ST_IDLE;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          // Stopping freezes the prescaler at this edge so RUN cycles per step stay at PRESCALE.
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = 16'd0;
            count_d = step_val;
            wrap_d  = step_wrap;
            if (step_val == target_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        ST_PAUSE: begin
          if (!stop && start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 7'd0;
      target_q <= 7'd0;
      presc_q  <= 16'd0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign tens  = 4'(count_q / 7'd10);
  assign ones  = 4'(count_q % 7'd10);
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: doc/mod100_timer_ctrl.md
# mod100_timer_ctrl

Sequencing controller for the team's 0–99 mod-100 counting datapath. It turns a free-running mod-100 counter into a start/stop/pause timer:
- a prescaler derives count ticks from `clk`;
- an FSM gates counting up or down from a loaded value until a programmable target is hit;
- it presents the count in binary and as two BCD digits for display logic.

It sits between the command/control logic and the display/event logic.

## Interface
- `PRESCALE`, default 10: `clk` cycles per count tick. Legal range 1–65535. A 16-bit prescaler counter is used.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: run/resume command, level-sampled each cycle.
- `stop` input 1: pause command.
- `clear` input 1: abort to IDLE, count := 0.
- `dir` input 1: 1 = count up, 0 = count down. Sampled only on each tick.
- `load_en` input 1: load `load_val` into count.
- `load_val` input 7: start value, legal 0–99.
- `target_val` input 7: terminal value, legal 0–99. Sampled and registered on an accepted `start` from IDLE/DONE.
- `count` output 7: current count, 0–99.
- `tens` output 4: BCD tens digit of `count`.
- `ones` output 4: BCD ones digit of `count`.
- `busy` output 1: high in RUN and PAUSE.
- `done` output 1: one-cycle pulse when the count reaches the target.
- `wrap` output 1: one-cycle pulse on a 99→0 or 0→99 step.
- `err` output 1: one-cycle pulse on a rejected load/start with an illegal value.

## Operation
- **Reset** (`rst_n`=0 at a clock edge): state=IDLE, count=0, prescaler=0, target register=0, and `busy`, `done`, `wrap`, `err` all 0. `tens`/`ones`=0.
- **Command priority** each cycle: `clear` > `stop` > `start` > `load_en`. Lower-priority commands in the same cycle are ignored.
- **IDLE**:
  - `load_en` with `load_val`≤99: count := `load_val`, stay IDLE.
  - `load_en` with `load_val`>99: count unchanged, `err` pulse.
  - `start` with `target_val`≤99: target := `target_val`, prescaler := 0, → RUN.
  - `start` with `target_val`>99: `err` pulse, stay IDLE.
- **RUN**:
  - Each cycle: if prescaler==`PRESCALE`-1, then prescaler := 0 and a tick occurs; otherwise prescaler += 1.
  - Tick, up direction: 99→0 with a `wrap` pulse, else +1.
  - Tick, down direction: 0→99 with a `wrap` pulse, else −1.
  - If the new count equals target: → DONE and `done` pulse.
  - `stop` → PAUSE.
  - `load_en` is ignored.
- **PAUSE**: count and prescaler are frozen. `start` → RUN, resuming the prescaler phase (no reset, target kept). `load_en` is ignored.
- **DONE**:
  - Count is held.
  - `load_en` behaves as in IDLE and moves to IDLE.
  - `start` behaves as from IDLE, re-sampling the target. If the target is unchanged, it runs a full 100-tick lap.
- **`clear`** from any state: → IDLE, count=0, prescaler=0. No `done`/`wrap` pulse that cycle.
- **Start with count==target**: no immediate `done`. `done` fires only on a tick that lands on the target.
- **Arithmetic**: count is never outside 0–99. `tens` = count/10 and `ones` = count%10, both combinational from the `count` register (zero latency, always consistent).

## Timing
- Commands are sampled at a rising edge. The state change is visible the following cycle.
- `start` sampled at edge E0 → RUN from E0. The first count step is at edge E0+`PRESCALE`. Subsequent steps are every `PRESCALE` edges.
- `PRESCALE`=1: count steps on every RUN cycle.
- `done` and `wrap` are registered and assert in the same cycle the new count is visible. They are high for exactly one cycle.
- A step 99→0 that is also the target asserts `wrap` and `done` together.
- `err` asserts the cycle after the offending command, for one cycle.
- Pause/resume preserves the tick spacing: total RUN cycles between steps always equals `PRESCALE`.
- `rst_n` low mid-RUN: full reset at that edge. Outputs are at reset values the next cycle.

## Test plan
- **Up count to target**: `PRESCALE`=4, `load_val`=5, `target_val`=8, `dir`=1, start → count 6, 7, 8 at 4-cycle spacing. `done` pulses once with count=8. State DONE, `busy`=0.
- **Down count with wrap**: load 1, target 97, `dir`=0 → steps 0, 99 (`wrap` pulse), 98, 97 (`done`). `tens`/`ones` go 9/9 → 9/8 → 9/7.
- **Pause/resume**: `PRESCALE`=10, start, stop after 6 RUN cycles, wait 20 cycles, start → first step lands 4 RUN cycles after resume. Count is frozen during PAUSE.
- **Illegal values**: `load_val`=100 in IDLE → `err` pulse, count unchanged. `target_val`=120 with start → `err`, stays IDLE, `busy`=0.
- **Priority and clear**: `clear`+`start` together in RUN at count 42 → IDLE, count=0, no `done`/`wrap`. `stop`+`start` together in RUN → PAUSE.
- **Reset and full lap**: synchronous `rst_n` low mid-RUN → all outputs 0 next cycle. Then start with target=0 from count 0, up direction → exactly 100 ticks, `wrap` and `done` together at 99→0.
